mul_div_datapath: RTL and testbench
===================================

# mul_div_datapath

Datapath responder for the project control unit. It executes the 5-bit control word `cs` on each rising clock edge and performs either an unsigned shift-add multiply (mode 0) or an unsigned restoring divide (mode 1) on `WIDTH`-bit operands. It reports `count_zero` back so the control unit knows when to stop sequencing. It sits directly beside the control unit: `cs` and `mode` come from it, and operands and results go to and from the surrounding test harness.

## Interface
- `WIDTH`, default 8: operand width in bits; must be at least 2.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `cs`  in  5: control word from the control unit; bit meanings are listed under Operation.
- `mode`  in  1: 0 = multiply, 1 = divide; sampled only on a load.
- `a_in`  in  WIDTH: multiplicand in mode 0, divisor in mode 1.
- `b_in`  in  WIDTH: multiplier in mode 0, dividend in mode 1.
- `result`  out  2*WIDTH: latched result. Mode 0: the product. Mode 1: {remainder, quotient}.
- `valid`  out  1: one-cycle pulse; asserted the cycle after `result` is latched.
- `count_zero`  out  1: high when the iteration counter equals 0.
- `div_by_zero`  out  1: sticky flag; set on a divide load with `a_in` = 0.

## Operation
- Internal registers:
  - `M` (WIDTH bits): operand.
  - `ACC` (WIDTH+1 bits): carry in mode 0, sign in mode 1.
  - `Q` (WIDTH bits).
  - `cnt` (clog2(WIDTH)+1 bits).
  - `mode_r` (1 bit).
- cs[0] LOAD:
  - `M` ← `a_in`, `Q` ← `b_in`, `ACC` ← 0, `cnt` ← WIDTH, `mode_r` ← `mode`.
  - `div_by_zero` ← (`mode` & (`a_in` == 0)).
- cs[1] ARITH:
  - mode_r = 0: if Q[0], `ACC` ← `ACC` + {0,M}; otherwise no change.
  - mode_r = 1: `ACC` ← `ACC` − {0,M} (two's complement, WIDTH+1 bits).
- cs[2] SHIFT, only when `cnt` ≠ 0:
  - mode_r = 0: {ACC,Q} ← {ACC,Q} >> 1, with 0 shifted in at the MSB.
  - mode_r = 1: {ACC,Q} ← {ACC,Q} << 1, with 0 shifted in at the LSB.
  - `cnt` ← `cnt` − 1.
  - When `cnt` = 0, SHIFT is ignored and no register changes.
- cs[3] RESTORE, mode 1 only:
  - If ACC[WIDTH] = 1: `ACC` ← `ACC` + {0,M} and Q[0] ← 0.
  - Otherwise Q[0] ← 1.
  - In mode 0, RESTORE is a no-op.
- cs[4] LATCH:
  - mode_r = 0: `result` ← {ACC[WIDTH-1:0], Q}.
  - mode_r = 1: `result` ← {ACC[WIDTH-1:0], Q}, i.e. {remainder, quotient}.
  - `valid` pulses high on the next cycle.
- Priority:
  - LOAD overrides cs[3:1] in the same cycle.
  - Among cs[3:1] only one executes per cycle, in priority cs[1] > cs[3] > cs[2].
  - cs[4] is independent. When combined with another bit, it latches the register values from *before* that edge.
- Control sequences:
  - Multiply: LOAD, then WIDTH × (ARITH, SHIFT), then LATCH.
  - Divide: LOAD, then WIDTH × (SHIFT, ARITH, RESTORE), then LATCH.
- cs = 0: hold all registers.
- Divide by zero: the sequence runs normally. The result is quotient = all ones, remainder = dividend. `div_by_zero` stays set until the next LOAD or reset.

## Timing
- Every `cs` action takes effect at the rising edge where it is sampled. Outputs are registered.
- `count_zero` is combinational from `cnt`.
- Reset values:
  - `result` = 0, `valid` = 0, `div_by_zero` = 0.
  - `cnt` = 0, so `count_zero` = 1.
  - `M`, `ACC`, `Q` = 0, `mode_r` = 0.
- Latency:
  - Multiply: 1 + 2·WIDTH + 1 edges from LOAD to LATCH, with `valid` high one cycle later. For WIDTH = 8 that is 18 edges to LATCH and `valid` on cycle 19.
  - Divide: 1 + 3·WIDTH + 1 edges.
- `valid` is high for exactly one cycle per LATCH. Back-to-back LATCH cycles keep `valid` high on consecutive cycles.
- Reset mid-operation: at that edge all registers return to their reset values, `cs` is ignored, and no `valid` is produced for the aborted operation.
- A LOAD mid-operation restarts cleanly. The previous `result` is retained until the next LATCH.

## Test plan
- Reset: hold `reset` = 1 for 2 edges with random `cs` → `result` = 0, `valid` = 0, `count_zero` = 1, `div_by_zero` = 0.
- Multiply, WIDTH = 8: 13 × 11 with the standard sequence → `result` = 16'h008F, `valid` a single pulse, `count_zero` = 1 before LATCH.
- Multiply carry case: 255 × 255 → `result` = 16'hFE01; exercises the ACC carry bit.
- Divide: 100 / 7 → `result` = 16'h020E (remainder 2, quotient 14). Also 7 / 100 → 16'h0700.
- Divide by zero: a_in = 0, b_in = 45 → `div_by_zero` = 1 after LOAD, `result` = 16'h2DFF. A following LOAD with nonzero `a_in` clears the flag.
- Abort and boundary cases:
  - Assert `reset` after the 5th SHIFT → no `valid` pulse, registers are 0.
  - Issue a SHIFT with `cnt` = 0 → no state change.
  - Issue LOAD with ARITH in the same cycle → only LOAD takes effect.

Source files
------------

// File: rtl/mul_div_datapath.sv
// mul_div_datapath
// ----------------
// Sequenced datapath for a shift-add multiplier (mode 0) and a restoring
// divider (mode 1). An external control unit drives one control word per
// clock. This block executes it and reports when the iteration counter
// reaches zero.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   cs[4:0]      control word:
//                  [0] LOAD     [1] ARITH    [2] SHIFT
//                  [3] RESTORE  [4] LATCH
//   mode         0 = multiply, 1 = divide (captured on LOAD)
//   a_in         multiplicand (mode 0) / divisor (mode 1)
//   b_in         multiplier (mode 0) / dividend (mode 1)
//   result       latched product, or {remainder, quotient}
//   valid        one-cycle pulse following each LATCH
//   count_zero   iteration counter is zero
//   div_by_zero  sticky flag, set by a divide LOAD with a_in == 0
module mul_div_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         cs,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               count_zero,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   m_reg, m_next;
  logic [WIDTH:0]     acc_reg, acc_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               mode_reg, mode_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               valid_reg, valid_next;
  logic               dbz_reg, dbz_next;

  always_comb begin
    m_next      = m_reg;
    acc_next    = acc_reg;
    q_next      = q_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    dbz_next    = dbz_reg;

    // LATCH always samples the pre-edge registers, so it is independent of
    // whichever other operation shares the cycle.
    result_next = cs[4] ? {acc_reg[WIDTH-1:0], q_reg} : result_reg;
    valid_next  = cs[4];

    if (cs[0]) begin
      m_next    = a_in;
      q_next    = b_in;
      acc_next  = '0;
      cnt_next  = CW'(WIDTH);
      mode_next = mode;
      dbz_next  = mode && (a_in == '0);
    end else if (cs[1]) begin
      if (mode_reg) begin
        // Trial subtraction; ACC[WIDTH] becomes the sign of the remainder.
        acc_next = acc_reg - {1'b0, m_reg};
      end else if (q_reg[0]) begin
        // ACC[WIDTH] keeps the carry so it is shifted back into the product.
        acc_next = acc_reg + {1'b0, m_reg};
      end
    end else if (cs[3]) begin
      if (mode_reg) begin
        if (acc_reg[WIDTH]) begin
          acc_next  = acc_reg + {1'b0, m_reg};
          q_next[0] = 1'b0;
        end else begin
          q_next[0] = 1'b1;
        end
      end
    end else if (cs[2] && (cnt_reg != '0)) begin
      if (mode_reg) begin
        {acc_next, q_next} = {acc_reg[WIDTH-1:0], q_reg, 1'b0};
      end else begin
        {acc_next, q_next} = {1'b0, acc_reg, q_reg[WIDTH-1:1]};
      end
      cnt_next = cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_reg      <= '0;
      acc_reg    <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      m_reg      <= m_next;
      acc_reg    <= acc_next;
      q_reg      <= q_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
      dbz_reg    <= dbz_next;
    end
  end

  assign result      = result_reg;
  assign valid       = valid_reg;
  assign div_by_zero = dbz_reg;
  assign count_zero  = (cnt_reg == '0);

endmodule

// File: tb/tb_mul_div_datapath.sv
// Testbench for mul_div_datapath (WIDTH = 8).
// The stimulus process plays the control-unit role and pushes the
// hand-computed result of each LATCH into a queue. A separate monitor pops
// and compares on every valid cycle.
module tb_mul_div_datapath;

  localparam int WIDTH = 8;

  logic               clock;
  logic               reset;
  logic [4:0]         cs;
  logic               mode;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] result;
  logic               valid;
  logic               count_zero;
  logic               div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] sb[$];

  mul_div_datapath #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .cs(cs),
    .mode(mode),
    .a_in(a_in),
    .b_in(b_in),
    .result(result),
    .valid(valid),
    .count_zero(count_zero),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every valid cycle must match the oldest outstanding LATCH.
  always @(negedge clock) begin
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 result=%h, expected no valid", result);
      end else begin
        logic [2*WIDTH-1:0] exp;
        exp = sb.pop_front();
        chk("result", 32'(result), 32'(exp));
      end
    end
  end

  task automatic step(input logic [4:0] c);
    @(negedge clock);
    cs = c;
  endtask

  task automatic do_load(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] extra);
    @(negedge clock);
    mode = m;
    a_in = a;
    b_in = b;
    cs   = 5'b00001 | extra;
  endtask

  task automatic latch(input logic [2*WIDTH-1:0] exp);
    @(negedge clock);
    sb.push_back(exp);
    cs = 5'b10000;
    step(5'b00000);
  endtask

  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] exp);
    do_load(1'b0, a, b, 5'b0);
    for (int i = 0; i < WIDTH; i++) begin
      step(5'b00010);
      step(5'b00100);
    end
    step(5'b00000);
    chk("mul_count_zero", 32'(count_zero), 32'd1);
    latch(exp);
  endtask

  task automatic div_iters();
    for (int i = 0; i < WIDTH; i++) begin
      step(5'b00100);
      step(5'b00010);
      step(5'b01000);
    end
  endtask

  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] exp, input logic exp_dbz);
    do_load(1'b1, a, b, 5'b0);
    step(5'b00000);
    chk("div_by_zero_after_load", 32'(div_by_zero), 32'(exp_dbz));
    div_iters();
    step(5'b00000);
    chk("div_count_zero", 32'(count_zero), 32'd1);
    latch(exp);
    chk("div_by_zero_after_latch", 32'(div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cs    = 5'b0;
    mode  = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Reset with random control words.
    repeat (2) begin
      @(negedge clock);
      cs = 5'($urandom_range(0, 31));
    end
    @(negedge clock);
    reset = 1'b0;
    cs    = 5'b0;
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_count_zero", 32'(count_zero), 32'd1);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);

    // Multiply 13 x 11 = 143.
    run_mul(8'd13, 8'd11, 16'h008F);

    // SHIFT with cnt = 0 must leave ACC/Q alone; re-latch shows the same product.
    step(5'b00100);
    step(5'b00000);
    chk("shift_at_zero_count_zero", 32'(count_zero), 32'd1);
    latch(16'h008F);

    // Carry case 255 x 255 = 65025.
    run_mul(8'd255, 8'd255, 16'hFE01);

    // Divides.
    run_div(8'd7, 8'd100, 16'h020E, 1'b0);
    run_div(8'd100, 8'd7, 16'h0700, 1'b0);

    // Divide by zero: quotient all ones, remainder = dividend, flag sticky.
    run_div(8'd0, 8'd45, 16'h2DFF, 1'b1);
    // Next LOAD with a nonzero divisor clears the flag: 200 / 1.
    run_div(8'd1, 8'd200, 16'h00C8, 1'b0);

    // LOAD together with ARITH: only LOAD acts (ACC = 0, Q = b_in).
    run_mul(8'd9, 8'd9, 16'h0051);
    do_load(1'b0, 8'd5, 8'd3, 5'b00010);
    step(5'b00000);
    chk("load_arith_count_zero", 32'(count_zero), 32'd0);
    latch(16'h0003);
    for (int i = 0; i < WIDTH; i++) begin
      step(5'b00010);
      step(5'b00100);
    end
    latch(16'h000F);

    // Abort: reset after the 5th SHIFT, with LATCH on the reset edge.
    do_load(1'b0, 8'd13, 8'd11, 5'b0);
    for (int i = 0; i < 5; i++) begin
      step(5'b00010);
      step(5'b00100);
    end
    @(negedge clock);
    reset = 1'b1;
    cs    = 5'b10000;
    @(negedge clock);
    reset = 1'b0;
    cs    = 5'b00000;
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_count_zero", 32'(count_zero), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    step(5'b10000);
    step(5'b00000);
    chk("abort_relatch_result", 32'(result), 32'h0);
    sb.push_back(16'h0000);
    repeat (3) step(5'b00000);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
